// File: rtl/periph_timer_irq_if.sv
// periph_timer_irq_if: CPU data-bus port of the timer/IO peripheral.
// The master drives the strobes, address and write data; the slave returns rdata.
interface periph_timer_irq_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output rd, wr, addr, wdata,
    input  rdata
  );

  modport slave (
    input  rd, wr, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/periph_timer_irq.sv
// periph_timer_irq: bus-mapped reload timer with IRQ, LED, switch, 7-seg regs.
// Define PERIPH_SYSTICK_EN to add a free-running SYSTICK counter at 0x18.
module periph_timer_irq #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_W     = 8,
  parameter int          SW_W      = 8,
  parameter int          DIGI_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  periph_timer_irq_if.slave bus,
  input  logic [SW_W-1:0]   switch,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  output logic              irqout
);

  localparam logic [2:0] OFF_TH   = 3'd0;
  localparam logic [2:0] OFF_TL   = 3'd1;
  localparam logic [2:0] OFF_TCON = 3'd2;
  localparam logic [2:0] OFF_LED  = 3'd3;
  localparam logic [2:0] OFF_SW   = 3'd4;
  localparam logic [2:0] OFF_DIGI = 3'd5;
`ifdef PERIPH_SYSTICK_EN
  localparam logic [2:0] OFF_SYS  = 3'd6;
`endif
  localparam logic [31:0] TL_MAX  = 32'hFFFF_FFFF;

  logic [31:0]       th_q, th_d;
  logic [31:0]       tl_q, tl_d;
  logic [2:0]        tcon_q, tcon_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DIGI_W-1:0] digi_q, digi_d;
  logic [SW_W-1:0]   sw_meta_q;
  logic [SW_W-1:0]   sw_q;
  logic [31:0]       rdata_d;

  logic       hit;
  logic       we;
  logic [2:0] sel;
  logic       unused_addr;

  assign hit         = (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign we          = bus.wr & hit;
  assign sel         = bus.addr[4:2];
  assign unused_addr = ^bus.addr[1:0];

`ifdef PERIPH_SYSTICK_EN
  logic [31:0] systick_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) systick_q <= '0;
    else        systick_q <= systick_q + 32'd1;
  end
`endif

  // Timer update first, bus write afterwards so software always wins.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    led_d  = led_q;
    digi_d = digi_q;
    if (tcon_q[0]) begin
      if (tl_q == TL_MAX) begin
        tl_d = th_q;
        if (tcon_q[1]) tcon_d[2] = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
    if (we) begin
      unique case (sel)
        OFF_TH:   th_d   = bus.wdata;
        OFF_TL:   tl_d   = bus.wdata;
        OFF_TCON: tcon_d = bus.wdata[2:0];
        OFF_LED:  led_d  = bus.wdata[LED_W-1:0];
        OFF_DIGI: digi_d = bus.wdata[DIGI_W-1:0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      digi_q    <= '0;
      sw_meta_q <= '0;
      sw_q      <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digi_q    <= digi_d;
      sw_meta_q <= switch;
      sw_q      <= sw_meta_q;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (bus.rd && hit) begin
      unique case (sel)
        OFF_TH:   rdata_d = th_q;
        OFF_TL:   rdata_d = tl_q;
        OFF_TCON: rdata_d = 32'(tcon_q);
        OFF_LED:  rdata_d = 32'(led_q);
        OFF_SW:   rdata_d = 32'(sw_q);
        OFF_DIGI: rdata_d = 32'(digi_q);
`ifdef PERIPH_SYSTICK_EN
        OFF_SYS:  rdata_d = systick_q;
`endif
        default:  rdata_d = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_d;
  assign led       = led_q;
  assign digi      = digi_q;
  assign irqout    = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_periph_timer_irq.sv
// tb_periph_timer_irq: directed tests for the timer/IO peripheral.
// Inputs change on negedge; outputs are read between edges.
module tb_periph_timer_irq;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam logic [31:0] A_TH  = BASE + 32'h00;
  localparam logic [31:0] A_TL  = BASE + 32'h04;
  localparam logic [31:0] A_TC  = BASE + 32'h08;
  localparam logic [31:0] A_LED = BASE + 32'h0C;
  localparam logic [31:0] A_SW  = BASE + 32'h10;
  localparam logic [31:0] A_DG  = BASE + 32'h14;
  localparam logic [31:0] A_SYS = BASE + 32'h18;
  localparam logic [31:0] A_1C  = BASE + 32'h1C;

  logic        clk;
  logic        reset;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;

  int n_cmp;
  int n_err;

  periph_timer_irq_if bus ();

  periph_timer_irq #(
    .BASE_ADDR (BASE),
    .LED_W     (8),
    .SW_W      (8),
    .DIGI_W    (12)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus.slave),
    .switch (switch),
    .led    (led),
    .digi   (digi),
    .irqout (irqout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; the write lands on the next posedge.
  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    bus.wr    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.wr    = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
    bus.rd   = 1'b1;
    bus.addr = a;
    #1;
    d        = bus.rdata;
    bus.rd   = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      rd_reg(BASE + 32'(i * 4), d);
      n_cmp++;
      if (d !== 32'h0) begin
        n_err++;
        $display("FAIL reset_rd[%0d] got %h exp 0", i, d);
      end
    end
    n_cmp++;
    if (irqout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_irq got %b exp 0", irqout);
    end
    n_cmp++;
    if ({led, digi} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_io got %h exp 0", {led, digi});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_timer_overflow;
    logic [31:0] d;
    wr_reg(A_TH, 32'hFFFF_FFFE);
    wr_reg(A_TL, 32'hFFFF_FFFE);
    wr_reg(A_TC, 32'h3);
    rd_reg(A_TL, d);
    n_cmp++;
    if (d !== 32'hFFFF_FFFE) begin
      n_err++;
      $display("FAIL tl_start got %h exp fffffffe", d);
    end
    @(negedge clk);
    rd_reg(A_TL, d);
    n_cmp++;
    if (d !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL tl_max got %h exp ffffffff", d);
    end
    rd_reg(A_TC, d);
    n_cmp++;
    if (d !== 32'h3 || irqout !== 1'b0) begin
      n_err++;
      $display("FAIL tcon_pre got %h/%b exp 3/0", d, irqout);
    end
    @(negedge clk);
    rd_reg(A_TL, d);
    n_cmp++;
    if (d !== 32'hFFFF_FFFE) begin
      n_err++;
      $display("FAIL tl_reload got %h exp fffffffe", d);
    end
    rd_reg(A_TC, d);
    n_cmp++;
    if (d !== 32'h7) begin
      n_err++;
      $display("FAIL tcon_ovf got %h exp 7", d);
    end
    n_cmp++;
    if (irqout !== 1'b1) begin
      n_err++;
      $display("FAIL irq_set got %b exp 1", irqout);
    end
  endtask

  task automatic test_irq_clear;
    logic [31:0] d;
    wr_reg(A_TC, 32'h3);
    n_cmp++;
    if (irqout !== 1'b0) begin
      n_err++;
      $display("FAIL irq_clear got %b exp 0", irqout);
    end
    rd_reg(A_TL, d);
    n_cmp++;
    if (d !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL tl_counting got %h exp ffffffff", d);
    end
  endtask

  task automatic test_simultaneous;
    logic [31:0] d;
    wr_reg(A_TL, 32'h5);
    rd_reg(A_TL, d);
    n_cmp++;
    if (d !== 32'h5) begin
      n_err++;
      $display("FAIL tl_write_wins got %h exp 5", d);
    end
    wr_reg(A_TC, 32'h3);
    wr_reg(A_TL, 32'hFFFF_FFFE);
    @(negedge clk);
    wr_reg(A_TC, 32'h1);
    rd_reg(A_TC, d);
    n_cmp++;
    if (d !== 32'h1 || irqout !== 1'b0) begin
      n_err++;
      $display("FAIL tcon_write_wins got %h/%b exp 1/0", d, irqout);
    end
    rd_reg(A_TL, d);
    n_cmp++;
    if (d !== 32'hFFFF_FFFE) begin
      n_err++;
      $display("FAIL tl_reload2 got %h exp fffffffe", d);
    end
    @(negedge clk);
    wr_reg(A_TH, 32'h100);
    rd_reg(A_TL, d);
    n_cmp++;
    if (d !== 32'hFFFF_FFFE) begin
      n_err++;
      $display("FAIL tl_old_th got %h exp fffffffe", d);
    end
    rd_reg(A_TH, d);
    n_cmp++;
    if (d !== 32'h100) begin
      n_err++;
      $display("FAIL th_new got %h exp 100", d);
    end
  endtask

  task automatic test_freeze;
    logic [31:0] d;
    wr_reg(A_TC, 32'h0);
    repeat (3) @(negedge clk);
    rd_reg(A_TL, d);
    n_cmp++;
    if (d !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL tl_frozen got %h exp ffffffff", d);
    end
    wr_reg(A_TC, 32'h6);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (irqout !== 1'b1) begin
      n_err++;
      $display("FAIL irq_hold got %b exp 1", irqout);
    end
    rd_reg(A_TL, d);
    n_cmp++;
    if (d !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL tl_frozen2 got %h exp ffffffff", d);
    end
    wr_reg(A_TC, 32'h0);
  endtask

  task automatic test_io;
    logic [31:0] d;
    switch = 8'hA5;
    rd_reg(A_SW, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL sw_sync0 got %h exp 0", d);
    end
    @(negedge clk);
    rd_reg(A_SW, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL sw_sync1 got %h exp 0", d);
    end
    @(negedge clk);
    rd_reg(A_SW, d);
    n_cmp++;
    if (d !== 32'hA5) begin
      n_err++;
      $display("FAIL sw_sync2 got %h exp a5", d);
    end
    wr_reg(A_LED, 32'hFFFF_FF3C);
    wr_reg(A_DG, 32'hFFFF_FABC);
    n_cmp++;
    if (led !== 8'h3C || digi !== 12'hABC) begin
      n_err++;
      $display("FAIL led_digi got %h/%h exp 3c/abc", led, digi);
    end
    rd_reg(A_DG, d);
    n_cmp++;
    if (d !== 32'hABC) begin
      n_err++;
      $display("FAIL digi_rd got %h exp abc", d);
    end
    rd_reg(A_LED, d);
    n_cmp++;
    if (d !== 32'h3C) begin
      n_err++;
      $display("FAIL led_rd got %h exp 3c", d);
    end
  endtask

  task automatic test_unmapped;
    logic [31:0] d;
    wr_reg(A_SW, 32'hFF);
    rd_reg(A_SW, d);
    n_cmp++;
    if (d !== 32'hA5) begin
      n_err++;
      $display("FAIL sw_ro got %h exp a5", d);
    end
    wr_reg(A_1C, 32'hFFFF_FFFF);
    rd_reg(A_1C, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL rd_1c got %h exp 0", d);
    end
    wr_reg(BASE + 32'h2C, 32'h11);
    n_cmp++;
    if (led !== 8'h3C || digi !== 12'hABC) begin
      n_err++;
      $display("FAIL out_win_wr got %h/%h exp 3c/abc", led, digi);
    end
    rd_reg(BASE + 32'h2C, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL out_win_rd got %h exp 0", d);
    end
    rd_reg(A_TH, d);
    n_cmp++;
    if (d !== 32'h100) begin
      n_err++;
      $display("FAIL th_kept got %h exp 100", d);
    end
    bus.addr = A_LED;
    #1;
    n_cmp++;
    if (bus.rdata !== 32'h0) begin
      n_err++;
      $display("FAIL no_rd got %h exp 0", bus.rdata);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    @(negedge clk);
    wr_reg(A_TC, 32'h7);
    n_cmp++;
    if (irqout !== 1'b1) begin
      n_err++;
      $display("FAIL pre_rst_irq got %b exp 1", irqout);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (irqout !== 1'b0 || led !== 8'h0 || digi !== 12'h0) begin
      n_err++;
      $display("FAIL async_rst got %b/%h/%h exp 0", irqout, led, digi);
    end
    rd_reg(A_TL, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL async_rst_tl got %h exp 0", d);
    end
  endtask

  task automatic test_systick;
    logic [31:0] d;
    logic [31:0] exp_d;
`ifdef PERIPH_SYSTICK_EN
    exp_d = 32'd5;
`else
    exp_d = 32'd0;
`endif
    @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    rd_reg(A_SYS, d);
    n_cmp++;
    if (d !== exp_d) begin
      n_err++;
      $display("FAIL systick got %h exp %h", d, exp_d);
    end
    wr_reg(A_SYS, 32'h1234);
    rd_reg(A_SYS, d);
    exp_d = (exp_d == 32'd0) ? 32'd0 : exp_d + 32'd1;
    n_cmp++;
    if (d !== exp_d) begin
      n_err++;
      $display("FAIL systick_ro got %h exp %h", d, exp_d);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b0;
    switch    = 8'h0;
    bus.rd    = 1'b0;
    bus.wr    = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    repeat (2) @(negedge clk);
    test_reset();
    test_timer_overflow();
    test_irq_clear();
    test_simultaneous();
    test_freeze();
    test_io();
    test_unmapped();
    test_async_reset();
    test_systick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
